// File: rtl/spawn_scheduler_pkg.sv
// Shared state encodings and level-schedule constants for the alien spawn scheduler.
// Imported by the level table, the scheduler top and anything that decodes its state.
package spawn_scheduler_pkg;

    localparam int SPAWN_BASE_INTERVAL = 50;
    localparam int SPAWN_INTERVAL_STEP = 5;
    localparam int SPAWN_MIN_INTERVAL  = 20;
    localparam int SPAWN_BASE_QUOTA    = 6;
    localparam int SPAWN_QUOTA_STEP    = 2;
    localparam int SPAWN_MAX_QUOTA     = 30;

    localparam int TIMER_W  = 6;
    localparam int REMAIN_W = 8;

    typedef enum logic [1:0] {
        SPAWN_IDLE = 2'd0,
        SPAWN_WAIT = 2'd1,
        SPAWN_REQ  = 2'd2,
        SPAWN_DONE = 2'd3
    } SpawnState;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/spawn_scheduler_if.sv
// Control/handshake bundle between the game control core and the spawn scheduler.
// The master side drives level and timing information; the scheduler is the slave.
interface spawn_scheduler_if #(
    parameter int LEVEL_SIZE = 4
);
    logic                  en;
    logic                  level_start;
    logic [LEVEL_SIZE-1:0] cur_level;
    logic                  tick;
    logic [3:0]            object_count;
    logic                  spawn_req;
    logic                  spawn_ack;
    logic [7:0]            remaining;
    logic                  all_spawned;

    modport master (
        output en, level_start, cur_level, tick, object_count, spawn_ack,
        input  spawn_req, remaining, all_spawned
    );

    modport slave (
        input  en, level_start, cur_level, tick, object_count, spawn_ack,
        output spawn_req, remaining, all_spawned
    );
endinterface

// File: rtl/spawn_scheduler_level_table.sv
// Combinational level -> (spawn interval, spawn quota) lookup.
// Both curves saturate: interval bottoms out at level 6, quota caps at level 12.
module spawn_level_table
    import spawn_scheduler_pkg::*;
#(
    parameter int LEVEL_SIZE = 4
) (
    input  logic [LEVEL_SIZE-1:0] i_level,
    output logic [TIMER_W-1:0]    o_interval,
    output logic [REMAIN_W-1:0]   o_quota
);

    int w_level;
    int w_steps;
    int w_interval;
    int w_quota;

    always_comb begin
        w_level    = int'(i_level);
        w_steps    = (w_level > 6) ? 6 : w_level;
        w_interval = SPAWN_BASE_INTERVAL - SPAWN_INTERVAL_STEP * w_steps;
        if (w_interval < SPAWN_MIN_INTERVAL) begin
            w_interval = SPAWN_MIN_INTERVAL;
        end
        // Levels >= 12 would exceed the cap; clamp before multiplying to avoid overflow on wide levels.
        if (w_level >= 12) begin
            w_quota = SPAWN_MAX_QUOTA;
        end else begin
            w_quota = SPAWN_BASE_QUOTA + SPAWN_QUOTA_STEP * w_level;
        end
        if (w_quota > SPAWN_MAX_QUOTA) begin
            w_quota = SPAWN_MAX_QUOTA;
        end
        o_interval = TIMER_W'(w_interval);
        o_quota    = REMAIN_W'(w_quota);
    end

endmodule

// File: rtl/spawn_scheduler.sv
// Per-level alien spawn scheduler: counts an interval in 10 Hz ticks, then requests
// one spawn from the event core, until the level quota is exhausted.
module spawn_scheduler
    import spawn_scheduler_pkg::*;
#(
    parameter int LEVEL_SIZE  = 4,
    parameter int MAX_OBJECTS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spawn_scheduler_if.slave   sched_bus
);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [TIMER_W-1:0]  r_timer;
    logic [TIMER_W-1:0]  w_timer_nxt;
    logic [TIMER_W-1:0]  r_interval;
    logic [TIMER_W-1:0]  w_interval_nxt;
    logic [REMAIN_W-1:0] r_remaining;
    logic [REMAIN_W-1:0] w_remaining_nxt;
    logic                r_spawn_req;
    logic                r_all_spawned;
    logic [TIMER_W-1:0]  w_tbl_interval;
    logic [REMAIN_W-1:0] w_tbl_quota;
    logic                w_ack;
    logic                w_room;

    spawn_level_table #(
        .LEVEL_SIZE (LEVEL_SIZE)
    ) u_level_table (
        .i_level    (sched_bus.cur_level),
        .o_interval (w_tbl_interval),
        .o_quota    (w_tbl_quota)
    );

    // An ack only counts against a request that is actually visible on the bus.
    assign w_ack  = sched_bus.en && sched_bus.spawn_ack && r_spawn_req &&
                    (r_state == ST_REQ) && (r_remaining != '0);
    assign w_room = int'(sched_bus.object_count) < MAX_OBJECTS;

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_interval_nxt  = r_interval;
        w_remaining_nxt = r_remaining;
        if (sched_bus.level_start) begin
            w_state_nxt     = ST_WAIT;
            w_interval_nxt  = w_tbl_interval;
            w_timer_nxt     = w_tbl_interval;
            w_remaining_nxt = w_tbl_quota;
        end else if (sched_bus.en) begin
            case (r_state)
                ST_WAIT: begin
                    if (r_timer != '0) begin
                        if (sched_bus.tick) begin
                            w_timer_nxt = r_timer - TIMER_W'(1);
                        end
                    end else if (w_room) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        w_remaining_nxt = r_remaining - REMAIN_W'(1);
                        if (r_remaining == REMAIN_W'(1)) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_timer_nxt = r_interval;
                            w_state_nxt = ST_WAIT;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_interval    <= '0;
            r_remaining   <= '0;
            r_spawn_req   <= 1'b0;
            r_all_spawned <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_interval    <= w_interval_nxt;
            r_remaining   <= w_remaining_nxt;
            r_spawn_req   <= (w_state_nxt == ST_REQ) && sched_bus.en;
            r_all_spawned <= (w_state_nxt == ST_DONE);
        end
    end

    assign sched_bus.spawn_req   = r_spawn_req;
    assign sched_bus.remaining   = r_remaining;
    assign sched_bus.all_spawned = r_all_spawned;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Directed self-checking bench for spawn_scheduler: level schedules, stall on object cap,
// withheld ack, enable freeze, level_start/ack collision and reset mid-request.
module tb_spawn_scheduler;

    localparam int LEVEL_SIZE  = 4;
    localparam int MAX_OBJECTS = 8;

    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;
    int   nTicks;

    spawn_scheduler_if #(.LEVEL_SIZE(LEVEL_SIZE)) sched_bus ();

    spawn_scheduler #(
        .LEVEL_SIZE  (LEVEL_SIZE),
        .MAX_OBJECTS (MAX_OBJECTS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sched_bus (sched_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against a hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold tick/ack for one rising edge, then sample 1 time unit after it.
    task automatic applyStimulus(input logic tickV, input logic ackV);
        sched_bus.tick      = tickV;
        sched_bus.spawn_ack = ackV;
        @(posedge clk);
        #1;
        sched_bus.tick      = 1'b0;
        sched_bus.spawn_ack = 1'b0;
    endtask

    task automatic pulseLevelStart(input logic [LEVEL_SIZE-1:0] lvl, input logic ackV);
        sched_bus.cur_level   = lvl;
        sched_bus.level_start = 1'b1;
        applyStimulus(1'b0, ackV);
        sched_bus.level_start = 1'b0;
    endtask

    // Tick every cycle until spawn_req rises; the timer hits 0 on the interval-th
    // tick and REQ follows one cycle later, so an interval N reports N+1.
    task automatic countTicksToReq(output int n);
        n = 0;
        while (sched_bus.spawn_req !== 1'b1 && n < 200) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
    endtask

    initial begin
        logic [LEVEL_SIZE-1:0] tblLevel [4];
        logic [7:0]            tblQuota [4];
        testsRun    = 0;
        testsFailed = 0;
        rst_n                  = 1'b0;
        sched_bus.en           = 1'b1;
        sched_bus.level_start  = 1'b0;
        sched_bus.cur_level    = '0;
        sched_bus.tick         = 1'b0;
        sched_bus.object_count = 4'd0;
        sched_bus.spawn_ack    = 1'b0;

        #3;
        checkOutput("reset_req", 32'(sched_bus.spawn_req), 0);
        checkOutput("reset_remaining", 32'(sched_bus.remaining), 0);
        checkOutput("reset_all_spawned", 32'(sched_bus.all_spawned), 0);
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // IDLE ignores tick and ack
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("idle_req", 32'(sched_bus.spawn_req), 0);
        checkOutput("idle_remaining", 32'(sched_bus.remaining), 0);

        // Level 0: interval 50, quota 6, ack as soon as the request shows
        pulseLevelStart(4'd0, 1'b0);
        checkOutput("l0_remaining_load", 32'(sched_bus.remaining), 6);
        checkOutput("l0_req_after_load", 32'(sched_bus.spawn_req), 0);
        for (int i = 0; i < 6; i++) begin
            countTicksToReq(nTicks);
            checkOutput("l0_ticks_to_req", 32'(nTicks), 51);
            applyStimulus(1'b0, 1'b1);
            checkOutput("l0_remaining", 32'(sched_bus.remaining), 32'(5 - i));
            checkOutput("l0_req_after_ack", 32'(sched_bus.spawn_req), 0);
            checkOutput("l0_all_spawned", 32'(sched_bus.all_spawned), (i == 5) ? 1 : 0);
        end
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("l0_done_hold", 32'(sched_bus.all_spawned), 1);
        checkOutput("l0_done_req", 32'(sched_bus.spawn_req), 0);
        checkOutput("l0_done_remaining", 32'(sched_bus.remaining), 0);

        // Level 9: interval 20, quota 24
        pulseLevelStart(4'd9, 1'b0);
        checkOutput("l9_all_spawned_clear", 32'(sched_bus.all_spawned), 0);
        checkOutput("l9_remaining_load", 32'(sched_bus.remaining), 24);
        countTicksToReq(nTicks);
        checkOutput("l9_ticks_to_req", 32'(nTicks), 21);

        // Level 15 started in the same cycle as an ack: reload wins, no decrement
        pulseLevelStart(4'd15, 1'b1);
        checkOutput("l15_collide_remaining", 32'(sched_bus.remaining), 30);
        checkOutput("l15_collide_req", 32'(sched_bus.spawn_req), 0);
        countTicksToReq(nTicks);
        checkOutput("l15_ticks_to_req", 32'(nTicks), 21);

        // Object cap reached: timer runs out but the request stalls
        sched_bus.object_count = 4'd8;
        applyStimulus(1'b0, 1'b1);
        checkOutput("stall_remaining", 32'(sched_bus.remaining), 29);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("stall_req_low", 32'(sched_bus.spawn_req), 0);
        end
        sched_bus.object_count = 4'd7;
        applyStimulus(1'b0, 1'b0);
        checkOutput("stall_release_req", 32'(sched_bus.spawn_req), 1);

        // Ack withheld for 10 cycles: request holds, one decrement on the ack
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("hold_req", 32'(sched_bus.spawn_req), 1);
            checkOutput("hold_remaining", 32'(sched_bus.remaining), 29);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("hold_ack_remaining", 32'(sched_bus.remaining), 28);
        checkOutput("hold_ack_req", 32'(sched_bus.spawn_req), 0);

        // Freeze at timer 17 for 30 ticks; 17 ticks (+1 cycle) remain afterwards
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        sched_bus.en = 1'b0;
        for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("freeze_remaining", 32'(sched_bus.remaining), 28);
        sched_bus.en = 1'b1;
        countTicksToReq(nTicks);
        checkOutput("freeze_ticks_to_req", 32'(nTicks), 18);

        // en low in REQ: request drops, acks are ignored, request returns with en
        sched_bus.en = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("en_low_req", 32'(sched_bus.spawn_req), 0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("en_low_ack_ignored", 32'(sched_bus.remaining), 28);
        sched_bus.en = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("en_high_req", 32'(sched_bus.spawn_req), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("en_high_ack", 32'(sched_bus.remaining), 27);

        // Reset mid-REQ: request cleared at once, nothing counted, back in IDLE
        countTicksToReq(nTicks);
        checkOutput("pre_reset_ticks", 32'(nTicks), 21);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req", 32'(sched_bus.spawn_req), 0);
        checkOutput("rst_remaining", 32'(sched_bus.remaining), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 60; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("post_rst_req", 32'(sched_bus.spawn_req), 0);
        checkOutput("post_rst_remaining", 32'(sched_bus.remaining), 0);
        checkOutput("post_rst_done", 32'(sched_bus.all_spawned), 0);

        // Quota boundaries around both saturation points
        tblLevel = '{4'd5, 4'd6, 4'd11, 4'd12};
        tblQuota = '{8'd16, 8'd18, 8'd28, 8'd30};
        for (int i = 0; i < 4; i++) begin
            pulseLevelStart(tblLevel[i], 1'b0);
            checkOutput("table_quota", 32'(sched_bus.remaining), 32'(tblQuota[i]));
        end
        countTicksToReq(nTicks);
        checkOutput("l12_ticks_to_req", 32'(nTicks), 21);
        pulseLevelStart(4'd5, 1'b0);
        countTicksToReq(nTicks);
        checkOutput("l5_ticks_to_req", 32'(nTicks), 26);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 SHALL have parameter LEVEL_SIZE, default 4, width of level input.
REQ-002 SHALL have parameter MAX_OBJECTS, default 8, live-object cap above which spawning stalls.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  high while game is in the in-game scene; low freezes the scheduler.
REQ-006 SHALL have port level_start  input  1  one-cycle pulse; loads the schedule for cur_level.
REQ-007 SHALL have port cur_level  input  LEVEL_SIZE  level sampled on level_start.
REQ-008 SHALL have port tick  input  1  one-cycle strobe, 10 Hz time base.
REQ-009 SHALL have port object_count  input  4  live objects reported by the event core.
REQ-010 SHALL have port spawn_req  output  1  request to insert one alien.
REQ-011 SHALL have port spawn_ack  input  1  event core accepted the request this cycle.
REQ-012 SHALL have port remaining  output  8  spawns left in current level.
REQ-013 SHALL have port all_spawned  output  1  high when the quota for the level is exhausted.

Function
REQ-014 SHALL implement states IDLE, WAIT, REQ, DONE.
REQ-015 SHALL, on level_start (any state, any en), load interval = 50 - 5*min(cur_level,6) ticks, quota = min(6 + 2*cur_level, 30), set remaining = quota, timer = interval, and enter WAIT next cycle.
REQ-016 SHALL give level_start priority over every other event in the same cycle, including spawn_ack.
REQ-017 SHALL, in WAIT with en high, decrement timer by 1 on each tick while timer > 0.
REQ-018 SHALL, in WAIT with timer == 0 and object_count < MAX_OBJECTS, enter REQ next cycle; with object_count >= MAX_OBJECTS, hold WAIT with timer at 0 (stall, no timer wrap).
REQ-019 SHALL assert spawn_req exactly while state == REQ and en is high; spawn_req is registered (no combinational path from inputs).
REQ-020 SHALL hold spawn_req until spawn_ack; spawn_ack outside REQ SHALL be ignored.
REQ-021 SHALL, on spawn_ack in REQ, decrement remaining; if the result is 0 enter DONE, else reload timer = interval and enter WAIT.
REQ-022 SHALL make the first spawn of a level occur no earlier than one full interval after level_start.
REQ-023 SHALL, while en is low, hold state, timer and remaining unchanged and ignore tick and spawn_ack.
REQ-024 SHALL assert all_spawned exactly when state == DONE; DONE exits only on level_start or reset.
REQ-025 SHALL never underflow remaining; quota 0 is impossible by table (minimum 6).
REQ-026 SHALL use saturating level lookup: cur_level >= 6 uses interval 20, cur_level >= 12 uses quota 30.

Reset
REQ-027 SHALL on rst_n low asynchronously set state = IDLE, timer = 0, remaining = 0, interval = 0, spawn_req = 0, all_spawned = 0.
REQ-028 SHALL stay in IDLE after reset release until level_start; tick and spawn_ack ignored in IDLE.
REQ-029 SHALL abort any pending request on reset mid-REQ with no spawn counted.

Structure
REQ-030 SHALL place the SpawnState enum and constants SPAWN_BASE_INTERVAL (50), SPAWN_INTERVAL_STEP (5), SPAWN_MIN_INTERVAL (20), SPAWN_BASE_QUOTA (6), SPAWN_QUOTA_STEP (2), SPAWN_MAX_QUOTA (30) in the shared typedefs/constants headers.
REQ-031 SHALL isolate the level-to-(interval, quota) lookup in one combinational sub-module, spawn_level_table.
REQ-032 SHALL replace the free-running 5 s spawn strobe in the control core; spawn_req/spawn_ack connect to the event core spawn path.

Verification
REQ-033 SHALL cover: level_start with cur_level=0, en=1, ack tied to req -> first spawn_req after 50 ticks, 6 spawns total, all_spawned high after 6th ack, remaining=0.
REQ-034 SHALL cover: cur_level=9 -> interval 20 ticks, quota 24; cur_level=15 -> interval 20, quota 30.
REQ-035 SHALL cover: object_count=8 when timer hits 0 -> spawn_req stays low; object_count drops to 7 -> spawn_req high within 2 cycles.
REQ-036 SHALL cover: spawn_ack withheld 10 cycles in REQ -> spawn_req held 10 cycles, remaining decremented once only after ack.
REQ-037 SHALL cover: en dropped mid-WAIT at timer=17 for 30 ticks -> timer still 17 on en re-assert; en low in REQ -> spawn_req low, ack ignored.
REQ-038 SHALL cover: level_start coincident with spawn_ack -> schedule reloaded, remaining = new quota, no decrement; rst_n pulse mid-REQ -> spawn_req low immediately, IDLE.
